// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment codes for digits 0..9, anode
// encoding and the digit/position widths used by the display and capture paths.
package seven_seg_pkg;

  localparam int DIGIT_W = 4;
  localparam int POS_N   = 4;
  localparam int POS_W   = 2;
  localparam int SEG_W   = 7;

  localparam logic [POS_N-1:0] AN_OFF = 4'hF;

  // Segments g..a, active-high
  localparam logic [SEG_W-1:0] SEG_D0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_D1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_D2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_D3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_D4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_D5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_D6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_D7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_D8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_D9 = 7'h6F;

  typedef struct packed {
    logic             sel;
    logic [POS_W-1:0] pos;
  } an_sel_t;

  // Only a single low anode selects a position; blanking and multi-low are idle.
  function automatic an_sel_t an_select(input logic [POS_N-1:0] an);
    an_sel_t r;
    r.sel = 1'b1;
    r.pos = '0;
    case (an)
      4'b1110: r.pos = 2'd0;
      4'b1101: r.pos = 2'd1;
      4'b1011: r.pos = 2'd2;
      4'b0111: r.pos = 2'd3;
      default: r.sel = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational seven-segment to BCD decoder; ok is low for any pattern that is
// not one of the ten digit codes.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0]   seg,
  output logic [DIGIT_W-1:0] digit,
  output logic               ok
);

  always_comb begin
    digit = '0;
    ok    = 1'b1;
    case (seg)
      SEG_D0:  digit = 4'd0;
      SEG_D1:  digit = 4'd1;
      SEG_D2:  digit = 4'd2;
      SEG_D3:  digit = 4'd3;
      SEG_D4:  digit = 4'd4;
      SEG_D5:  digit = 4'd5;
      SEG_D6:  digit = 4'd6;
      SEG_D7:  digit = 4'd7;
      SEG_D8:  digit = 4'd8;
      SEG_D9:  digit = 4'd9;
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Sniffs a multiplexed active-low-anode seven-segment bus, debounces each dwell
// and reassembles the four displayed digits into a 16-bit BCD frame.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        code_err
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

  logic [POS_N-1:0]                 an_p0;
  logic [7:0]                       seg_p0;
  logic [CNT_W-1:0]                 cnt;
  logic                             acc;
  logic [POS_N-1:0]                 seen;
  logic [POS_N-1:0][DIGIT_W-1:0]    shadow;

  logic [DIGIT_W-1:0]               dec_digit;
  logic                             dec_ok;
  an_sel_t                          sel;
  logic                             changed;
  logic                             accept;
  logic [POS_N-1:0]                 seen_upd;
  logic [POS_N-1:0][DIGIT_W-1:0]    shadow_upd;

  seven_seg_decode u_decode (
    .seg   (seg_p0[SEG_W-1:0]),
    .digit (dec_digit),
    .ok    (dec_ok)
  );

  always_comb begin
    sel        = an_select(an_p0);
    changed    = (an != an_p0) || (seg != seg_p0);
    accept     = (cnt == CNT_MAX) && !acc && sel.sel;
    shadow_upd = shadow;
    shadow_upd[sel.pos] = dec_digit;
    seen_upd   = seen | (POS_N'(1) << sel.pos);
  end

  // Stage p0: pin sampling and dwell stability tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_p0  <= AN_OFF;
      seg_p0 <= '0;
      cnt    <= '0;
      acc    <= 1'b0;
    end else begin
      an_p0  <= an;
      seg_p0 <= seg;
      if (changed) begin
        cnt <= CNT_W'(1);
        acc <= 1'b0;
      end else begin
        if (cnt != CNT_MAX)
          cnt <= cnt + CNT_W'(1);
        if (accept)
          acc <= 1'b1;
      end
    end
  end

  // Stage p1: per-position capture and frame assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen        <= '0;
      shadow      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      code_err    <= 1'b0;
      if (accept) begin
        if (dec_ok) begin
          shadow <= shadow_upd;
          if (&seen_upd) begin
            value       <= shadow_upd;
            value_valid <= 1'b1;
            seen        <= '0;
          end else begin
            seen <= seen_upd;
          end
        end else begin
          code_err <= 1'b1;
          seen     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: dwell-level stimulus with a run/frame reference
// model predicting the edge and contents of every value_valid / code_err pulse.
module tb_seven_seg_capture;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        value_valid;
  logic        code_err;

  seven_seg_capture #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .value_valid (value_valid),
    .code_err    (code_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t;
    int          kind;   // 1 = frame, 2 = code error
    logic [15:0] v;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  int checks = 0;
  int errors = 0;
  int edges  = 0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // reference model state
  logic [11:0] run_pat;
  int          run_start;
  int          run_len;
  bit          run_acc;
  bit          m_seen [4];
  int          m_digit [4];
  logic [15:0] m_value;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) edges <= edges + 1;

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (value_valid || code_err)) begin
      check_eq("pulse_exclusive", {31'd0, value_valid & code_err}, 32'd0);
      e.t    = edges;
      e.kind = value_valid ? 1 : 2;
      e.v    = value;
      obs_q.push_back(e);
    end
  end

  task automatic model_reset();
    run_pat = {4'hF, 8'h00};
    run_len = 0;
    run_acc = 1'b0;
    run_start = edges;
    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
    m_value = 16'h0000;
  endtask

  task automatic model_accept(input logic [3:0] a, input logic [7:0] s, input int t);
    int   pos;
    int   d;
    bit   all;
    ev_t  e;
    pos = -1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] m;
      m = 4'hF;
      m[i] = 1'b0;
      if (a == m) pos = i;
    end
    if (pos < 0) return;
    d = -1;
    for (int i = 0; i < 10; i++)
      if (pat[i] == s[6:0]) d = i;
    e.t = t;
    if (d < 0) begin
      for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
      e.kind = 2;
      e.v    = m_value;
      exp_q.push_back(e);
      return;
    end
    m_digit[pos] = d;
    m_seen[pos]  = 1'b1;
    all = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
    if (all) begin
      int acc_v;
      acc_v = 0;
      for (int i = 0; i < 4; i++) acc_v += m_digit[i] * (16 ** i);
      m_value = acc_v[15:0];
      for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
      e.kind = 1;
      e.v    = m_value;
      exp_q.push_back(e);
    end
  endtask

  // Present a pattern on the pins for len edges; called on a falling edge.
  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int len);
    an  = a;
    seg = s;
    if ({a, s} != run_pat) begin
      run_pat   = {a, s};
      run_start = edges;
      run_len   = 0;
      run_acc   = 1'b0;
    end
    run_len += len;
    if (!run_acc && run_len >= SETTLE) begin
      run_acc = 1'b1;
      model_accept(a, s, run_start + SETTLE + 1);
    end
    repeat (len) @(negedge clk);
  endtask

  task automatic hold_digit(input int pos, input int d, input int len);
    logic [3:0] a;
    a = 4'hF;
    a[pos] = 1'b0;
    hold(a, {1'b0, pat[d]}, len);
  endtask

  task automatic idle(input int len);
    hold(4'hF, 8'h00, len);
  endtask

  task automatic compare_events(input string tag);
    int n;
    #2;
    check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_edge"},  obs_q[i].t,    exp_q[i].t);
      check_eq({tag, "_kind"},  obs_q[i].kind, exp_q[i].kind);
      check_eq({tag, "_value"}, {16'd0, obs_q[i].v}, {16'd0, exp_q[i].v});
    end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    an  = 4'hF;
    seg = 8'h00;
    #1;
    check_eq("rst_value", {16'd0, value}, 32'd0);
    check_eq("rst_valid", {31'd0, value_valid}, 32'd0);
    check_eq("rst_err",   {31'd0, code_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    an  = 4'hF;
    seg = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();
    idle(3);

    // in-order frame
    hold_digit(0, 1, 6);
    hold_digit(1, 2, 6);
    hold_digit(2, 3, 6);
    hold_digit(3, 4, 6);
    idle(8);
    check_eq("inorder_value", {16'd0, value}, 32'h4321);
    compare_events("inorder");

    // glitch rejection on position 2
    hold_digit(0, 5, 6);
    hold_digit(1, 6, 6);
    hold(4'b1011, 8'h5B, 3);
    hold(4'b1011, 8'h4F, 6);
    hold_digit(3, 0, 6);
    idle(8);
    check_eq("glitch_value", {16'd0, value}, 32'h0365);
    compare_events("glitch");

    // invalid pattern discards the partial frame
    hold_digit(0, 1, 6);
    hold_digit(1, 1, 6);
    hold(4'b1011, 8'h00, 6);
    hold_digit(3, 9, 6);
    hold_digit(0, 8, 6);
    hold_digit(1, 7, 6);
    hold_digit(2, 6, 6);
    idle(8);
    check_eq("invalid_value", {16'd0, value}, 32'h9678);
    compare_events("invalid");

    // out-of-order, repeated position, ignored anodes
    hold_digit(3, 2, 6);
    idle(2);
    hold_digit(1, 5, 6);
    idle(1);
    hold_digit(1, 8, 6);
    hold(4'b0011, {1'b0, pat[4]}, 6);
    hold_digit(0, 0, 5);
    idle(3);
    hold_digit(2, 7, 6);
    idle(8);
    check_eq("ooo_value", {16'd0, value}, 32'h2780);
    compare_events("ooo");

    // reset mid-frame
    hold_digit(0, 3, 6);
    hold_digit(1, 3, 6);
    hold_digit(2, 3, 6);
    compare_events("prerst");
    do_reset();
    hold_digit(3, 5, 6);
    idle(8);
    compare_events("postrst_one");
    hold_digit(0, 1, 6);
    hold_digit(1, 2, 6);
    hold_digit(2, 3, 6);
    hold_digit(3, 4, 6);
    idle(8);
    compare_events("postrst_full");

    // indefinite hold accepts once and completes a later frame
    hold(4'b1110, 8'h06, 50);
    compare_events("hold_quiet");
    hold_digit(1, 9, 5);
    hold_digit(2, 0, 5);
    hold_digit(3, 6, 5);
    idle(8);
    compare_events("hold_frame");

    // randomized dwells
    for (int k = 0; k < 400; k++) begin
      logic [3:0] a;
      logic [7:0] s;
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        a = 4'hF;
        a[$urandom_range(0, 3)] = 1'b0;
      end else if (r < 8) begin
        a = 4'hF;
      end else begin
        a = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) < 8)
        s = {1'($urandom_range(0, 1)), pat[$urandom_range(0, 9)]};
      else
        s = 8'($urandom_range(0, 255));
      hold(a, s, $urandom_range(1, 8));
    end
    idle(10);
    compare_events("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
